// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: per-FU result request channels plus the shared
// scoreboard writeback port. The arbiter uses the slave modport.
interface wb_arbiter_if #(
    parameter int unsigned NumReq    = 3,
    parameter int unsigned IdxWidth  = 3,
    parameter int unsigned DataWidth = 32
);
    logic [NumReq-1:0]                req_valid;
    logic [NumReq-1:0]                req_ready;
    logic [NumReq-1:0][IdxWidth-1:0]  req_idx;
    logic [NumReq-1:0][DataWidth-1:0] req_data;

    logic                             wb_valid;
    logic                             wb_ready;
    logic [IdxWidth-1:0]              wb_idx;
    logic [DataWidth-1:0]             wb_data;
    logic [NumReq-1:0]                wb_src;

    modport master (
        output req_valid, req_idx, req_data, wb_ready,
        input  req_ready, wb_valid, wb_idx, wb_data, wb_src
    );

    modport slave (
        input  req_valid, req_idx, req_data, wb_ready,
        output req_ready, wb_valid, wb_idx, wb_data, wb_src
    );
endinterface

// File: rtl/wb_arbiter.sv
// Scoreboard writeback arbiter: one result buffer per FU, round-robin grant onto a
// single valid/ready port. Define WB_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module wb_arbiter #(
    parameter int unsigned NumReq    = 3,
    parameter int unsigned IdxWidth  = 3,
    parameter int unsigned DataWidth = 32
) (
    input logic         clock,
    input logic         reset_n,
    input logic         flush,
    wb_arbiter_if.slave bus
);

    logic [NumReq-1:0]                full_q;
    logic [NumReq-1:0][IdxWidth-1:0]  idx_q;
    logic [NumReq-1:0][DataWidth-1:0] data_q;

    logic [NumReq-1:0]                grant_oh;
    logic [NumReq-1:0]                drain;
    logic [NumReq-1:0]                ready_c;
    logic [NumReq-1:0]                load;
    logic [IdxWidth-1:0]              idx_mux;
    logic [DataWidth-1:0]             data_mux;

    // A full buffer being drained this cycle may be refilled on the same edge.
    always_comb begin
        drain   = grant_oh & {NumReq{bus.wb_ready}};
        ready_c = ~full_q | drain;
        load    = bus.req_valid & ready_c & {NumReq{~flush}};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full_q <= '0;
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NumReq; i++) begin
                if (load[i]) begin
                    full_q[i] <= 1'b1;
                    idx_q[i]  <= bus.req_idx[i];
                    data_q[i] <= bus.req_data[i];
                end else if (flush || drain[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
        end
    end

`ifdef WB_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_oh = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (full_q[i] && (grant_oh == '0)) begin
                grant_oh[i] = 1'b1;
            end
        end
    end
`else
    localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [PtrW-1:0] ptr_q;
    logic [PtrW-1:0] grant_idx;
    logic            found;
    logic            handshake;

    // Two passes give the wrapped search: first indices at/above the pointer, then below it.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (!found && full_q[i] && (i >= 32'(ptr_q))) begin
                found       = 1'b1;
                grant_oh[i] = 1'b1;
                grant_idx   = PtrW'(i);
            end
        end
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (!found && full_q[i]) begin
                found       = 1'b1;
                grant_oh[i] = 1'b1;
                grant_idx   = PtrW'(i);
            end
        end
    end

    assign handshake = (|full_q) & bus.wb_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (handshake) begin
            ptr_q <= (grant_idx == PtrW'(NumReq - 1)) ? '0 : grant_idx + PtrW'(1);
        end
    end
`endif

    always_comb begin
        idx_mux  = '0;
        data_mux = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (grant_oh[i]) begin
                idx_mux  = idx_q[i];
                data_mux = data_q[i];
            end
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.wb_valid  = |full_q;
    assign bus.wb_src    = grant_oh;
    assign bus.wb_idx    = idx_mux;
    assign bus.wb_data   = data_mux;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: inputs driven on the falling edge,
// outputs sampled 1ns later, state advances on the rising edge.
module tb_wb_arbiter;

    localparam int unsigned NumReq    = 3;
    localparam int unsigned IdxWidth  = 3;
    localparam int unsigned DataWidth = 32;

    logic clock;
    logic reset_n;
    logic flush;

    int passed;
    int total;

    wb_arbiter_if #(
        .NumReq   (NumReq),
        .IdxWidth (IdxWidth),
        .DataWidth(DataWidth)
    ) bus ();

    wb_arbiter #(
        .NumReq   (NumReq),
        .IdxWidth (IdxWidth),
        .DataWidth(DataWidth)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .flush  (flush),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input logic [2:0] v, input logic [2:0] i0, input logic [2:0] i1,
                           input logic [2:0] i2);
        bus.req_valid   = v;
        bus.req_idx[0]  = i0;
        bus.req_idx[1]  = i1;
        bus.req_idx[2]  = i2;
        bus.req_data[0] = 32'hD000_0000 | 32'(i0);
        bus.req_data[1] = 32'hD100_0000 | 32'(i1);
        bus.req_data[2] = 32'hD200_0000 | 32'(i2);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        flush = 1'b0;
        bus.wb_ready = 1'b0;
        set_req(3'b000, 3'd0, 3'd0, 3'd0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        flush = 1'b0;
        bus.wb_ready = 1'b0;
        set_req(3'b000, 3'd0, 3'd0, 3'd0);
        #1 reset_n = 1'b0;
        @(negedge clock);
        #1;
        total++; if (bus.wb_valid !== 1'b0) $display("FAIL reset_wb_valid: got %b expected 0", bus.wb_valid); else passed++;
        total++; if (bus.wb_src !== 3'b000) $display("FAIL reset_wb_src: got %b expected 000", bus.wb_src); else passed++;
        total++; if (bus.wb_idx !== 3'd0) $display("FAIL reset_wb_idx: got %0d expected 0", bus.wb_idx); else passed++;
        total++; if (bus.wb_data !== 32'h0) $display("FAIL reset_wb_data: got %h expected 0", bus.wb_data); else passed++;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        total++; if (bus.req_ready !== 3'b111) $display("FAIL reset_req_ready: got %b expected 111", bus.req_ready); else passed++;
    endtask

    task automatic test_single();
        @(negedge clock);
        bus.wb_ready = 1'b1;
        set_req(3'b010, 3'd0, 3'd5, 3'd0);
        bus.req_data[1] = 32'hDEAD_BEEF;
        #1;
        total++; if (bus.wb_valid !== 1'b0) $display("FAIL single_latency: got wb_valid %b expected 0", bus.wb_valid); else passed++;
        @(negedge clock);
        set_req(3'b000, 3'd0, 3'd0, 3'd0);
        #1;
        total++; if (bus.wb_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", bus.wb_valid); else passed++;
        total++; if (bus.wb_src !== 3'b010) $display("FAIL single_src: got %b expected 010", bus.wb_src); else passed++;
        total++; if (bus.wb_idx !== 3'd5) $display("FAIL single_idx: got %0d expected 5", bus.wb_idx); else passed++;
        total++; if (bus.wb_data !== 32'hDEAD_BEEF) $display("FAIL single_data: got %h expected deadbeef", bus.wb_data); else passed++;
        @(negedge clock);
        #1;
        total++; if (bus.wb_valid !== 1'b0) $display("FAIL single_retired: got %b expected 0", bus.wb_valid); else passed++;
        // All three full with pointer at 2: order exposes the pointer value.
        bus.wb_ready = 1'b0;
        set_req(3'b111, 3'd1, 3'd2, 3'd3);
        @(negedge clock);
        set_req(3'b000, 3'd0, 3'd0, 3'd0);
        bus.wb_ready = 1'b1;
`ifdef WB_ARB_FIXED_PRIO_EN
        #1;
        total++; if (bus.wb_src !== 3'b001) $display("FAIL ptr_order0: got %b expected 001", bus.wb_src); else passed++;
        @(negedge clock); #1;
        total++; if (bus.wb_src !== 3'b010) $display("FAIL ptr_order1: got %b expected 010", bus.wb_src); else passed++;
        @(negedge clock); #1;
        total++; if (bus.wb_src !== 3'b100) $display("FAIL ptr_order2: got %b expected 100", bus.wb_src); else passed++;
`else
        #1;
        total++; if (bus.wb_src !== 3'b100) $display("FAIL ptr_order0: got %b expected 100", bus.wb_src); else passed++;
        @(negedge clock); #1;
        total++; if (bus.wb_src !== 3'b001) $display("FAIL ptr_order1: got %b expected 001", bus.wb_src); else passed++;
        @(negedge clock); #1;
        total++; if (bus.wb_src !== 3'b010) $display("FAIL ptr_order2: got %b expected 010", bus.wb_src); else passed++;
`endif
        @(negedge clock); #1;
        total++; if (bus.wb_valid !== 1'b0) $display("FAIL ptr_drained: got %b expected 0", bus.wb_valid); else passed++;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_idx [3];
        logic [2:0] exp_src [3];
        do_reset();
        set_req(3'b111, 3'd1, 3'd2, 3'd3);
        @(negedge clock);
        bus.wb_ready = 1'b1;
`ifdef WB_ARB_FIXED_PRIO_EN
        // FU0 refilled every cycle keeps the grant.
        for (int k = 0; k < 4; k++) begin
            set_req(3'b001, 3'(k + 4), 3'd2, 3'd3);
            #1;
            total++; if (bus.wb_src !== 3'b001) $display("FAIL starve_src%0d: got %b expected 001", k, bus.wb_src); else passed++;
            @(negedge clock);
        end
        set_req(3'b000, 3'd0, 3'd0, 3'd0);
        #1;
        total++; if (bus.wb_idx !== 3'd7) $display("FAIL starve_last: got %0d expected 7", bus.wb_idx); else passed++;
        @(negedge clock);
`else
        set_req(3'b000, 3'd0, 3'd0, 3'd0);
`endif
        exp_idx = '{3'd1, 3'd2, 3'd3};
        exp_src = '{3'b001, 3'b010, 3'b100};
`ifdef WB_ARB_FIXED_PRIO_EN
        exp_idx[0] = 3'd7;
        for (int k = 1; k < 3; k++) begin
`else
        for (int k = 0; k < 3; k++) begin
`endif
            #1;
            total++; if (bus.wb_idx !== exp_idx[k]) $display("FAIL rr_idx%0d: got %0d expected %0d", k, bus.wb_idx, exp_idx[k]); else passed++;
            total++; if (bus.wb_src !== exp_src[k]) $display("FAIL rr_src%0d: got %b expected %b", k, bus.wb_src, exp_src[k]); else passed++;
            @(negedge clock);
        end
        #1;
        total++; if (bus.wb_valid !== 1'b0) $display("FAIL rr_empty: got %b expected 0", bus.wb_valid); else passed++;
        // Pointer back at 0: buffer 0 wins over buffer 1.
        bus.wb_ready = 1'b0;
        set_req(3'b011, 3'd4, 3'd5, 3'd0);
        @(negedge clock);
        set_req(3'b000, 3'd0, 3'd0, 3'd0);
        #1;
        total++; if (bus.wb_src !== 3'b001) $display("FAIL rr_ptr_zero: got %b expected 001", bus.wb_src); else passed++;
        bus.wb_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_backpressure();
        do_reset();
        set_req(3'b100, 3'd0, 3'd0, 3'd4);
        bus.req_data[2] = 32'h11;
        @(negedge clock);
        set_req(3'b100, 3'd0, 3'd0, 3'd6);
        bus.req_data[2] = 32'h66;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (bus.wb_idx !== 3'd4 || bus.wb_data !== 32'h11 || bus.wb_src !== 3'b100 || bus.wb_valid !== 1'b1)
                $display("FAIL bp_hold%0d: got v=%b src=%b idx=%0d data=%h expected v=1 src=100 idx=4 data=11",
                         k, bus.wb_valid, bus.wb_src, bus.wb_idx, bus.wb_data);
            else passed++;
            total++; if (bus.req_ready !== 3'b011) $display("FAIL bp_ready%0d: got %b expected 011", k, bus.req_ready); else passed++;
            @(negedge clock);
        end
        bus.wb_ready = 1'b1;
        #1;
        total++; if (bus.req_ready !== 3'b111) $display("FAIL bp_release_ready: got %b expected 111", bus.req_ready); else passed++;
        @(negedge clock);
        set_req(3'b000, 3'd0, 3'd0, 3'd0);
        #1;
        total++; if (bus.wb_idx !== 3'd6 || bus.wb_data !== 32'h66 || bus.wb_src !== 3'b100)
            $display("FAIL bp_refill: got src=%b idx=%0d data=%h expected src=100 idx=6 data=66", bus.wb_src, bus.wb_idx, bus.wb_data);
        else passed++;
        @(negedge clock); #1;
        total++; if (bus.wb_valid !== 1'b0) $display("FAIL bp_drained: got %b expected 0", bus.wb_valid); else passed++;
    endtask

    task automatic test_flush();
        int seen;
        do_reset();
        set_req(3'b101, 3'd1, 3'd0, 3'd3);
        @(negedge clock);
        flush = 1'b1;
        set_req(3'b010, 3'd0, 3'd7, 3'd0);
        @(negedge clock);
        flush = 1'b0;
        set_req(3'b000, 3'd0, 3'd0, 3'd0);
        #1;
        total++; if (bus.wb_valid !== 1'b0) $display("FAIL flush_valid: got %b expected 0", bus.wb_valid); else passed++;
        total++; if (bus.req_ready !== 3'b111) $display("FAIL flush_ready: got %b expected 111", bus.req_ready); else passed++;
        bus.wb_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock); #1;
            if (bus.wb_valid === 1'b1) seen++;
        end
        total++; if (seen !== 0) $display("FAIL flush_dropped: got %0d writebacks expected 0", seen); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [2:0] na;
        logic [2:0] nb;
        logic [2:0] rr;
        logic [2:0] exp_idx [6];
        logic [2:0] exp_src [6];
        exp_idx = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd6};
        exp_src = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
        do_reset();
        na = 3'd0;
        nb = 3'd4;
        bus.wb_ready = 1'b1;
        for (int k = -1; k < 6; k++) begin
            set_req(3'b011, na, nb, 3'd0);
            #1;
            if (k < 0) begin
                total++; if (bus.wb_valid !== 1'b0) $display("FAIL b2b_start: got %b expected 0", bus.wb_valid); else passed++;
            end else begin
                total++; if (bus.wb_idx !== exp_idx[k] || bus.wb_src !== exp_src[k])
                    $display("FAIL b2b_%0d: got src=%b idx=%0d expected src=%b idx=%0d", k, bus.wb_src, bus.wb_idx, exp_src[k], exp_idx[k]);
                else passed++;
            end
            rr = bus.req_ready;
            if (rr[0]) na = na + 3'd1;
            if (rr[1]) nb = nb + 3'd1;
            @(negedge clock);
        end
        set_req(3'b000, 3'd0, 3'd0, 3'd0);
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_async_reset();
        do_reset();
        set_req(3'b010, 3'd0, 3'd2, 3'd0);
        @(negedge clock);
        set_req(3'b000, 3'd0, 3'd0, 3'd0);
        #1;
        total++; if (bus.wb_valid !== 1'b1) $display("FAIL areset_pre: got %b expected 1", bus.wb_valid); else passed++;
        #2 reset_n = 1'b0;
        #1;
        total++; if (bus.wb_valid !== 1'b0 || bus.wb_src !== 3'b000 || bus.wb_data !== 32'h0)
            $display("FAIL areset_immediate: got v=%b src=%b data=%h expected v=0 src=000 data=0", bus.wb_valid, bus.wb_src, bus.wb_data);
        else passed++;
        @(negedge clock);
        reset_n = 1'b1;
        bus.wb_ready = 1'b1;
        #1;
        total++; if (bus.req_ready !== 3'b111) $display("FAIL areset_ready: got %b expected 111", bus.req_ready); else passed++;
        @(negedge clock); #1;
        total++; if (bus.wb_valid !== 1'b0) $display("FAIL areset_empty: got %b expected 0", bus.wb_valid); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
